pipeline_stall_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_stall_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: merges load-use, branch-taken and
// data-memory handshake into per-stage enables/flushes, with timeout, halt and perf counters.
module pipeline_stall_ctrl #(
  parameter int unsigned WAIT_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WW = $clog2(WAIT_TIMEOUT + 1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;
  localparam logic [1:0] ST_ERROR    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          advance;
  logic          cnt_active;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    advance     = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (dmem_req && !dmem_ready) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WW'(1);
        end else begin
          advance = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          advance = 1'b1;
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (wait_q == WW'(WAIT_TIMEOUT)) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Branch flush wins over load-use: the stalled instruction is on the wrong path anyway.
    if (advance) begin
      if (br_taken) begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00111;
        id_ex_flush = 1'b1;
      end else begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
      end
    end

    if (rst) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00000;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
    end
  end

  assign halted     = !rst && (state_q == ST_HALT);
  assign mem_err    = !rst && (state_q == ST_ERROR);
  assign cnt_active = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_active) begin
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
